// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 peripheral writing a small register bank that drives the PWM stage.
// Ports: clk/rst (sync, active-high); sclk/copi/ncs asynchronous SPI inputs; cipo readback data;
// en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle = registers 0..4;
// wr_strobe pulses for one cycle when a register is written.
// Option: define SPI_READBACK_EN to return register contents on cipo for read frames.
module spi_reg_bank #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_REGS    = 5,
    parameter int ADDR_W      = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       cipo,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe
);
    localparam int FRAME_W = ADDR_W + 9;
    localparam int CNT_W = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(FRAME_W + 1);
    localparam logic [ADDR_W-1:0] ADDR_LIM = ADDR_W'(NUM_REGS);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t state_q, state_n;
    logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync;
    logic sclk_d, ncs_d;
    logic sclk_s, copi_s, ncs_s;
    logic sclk_rise, ncs_rise, ncs_fall;
    logic shift_en, do_write;
    logic [CNT_W-1:0] cnt;
    logic [FRAME_W-1:0] sr;
    logic [ADDR_W-1:0] addr;
    logic [7:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            copi_sync <= '0;
            ncs_sync  <= '1;
            sclk_d    <= 1'b0;
            ncs_d     <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
            sclk_d    <= sclk_s;
            ncs_d     <= ncs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign copi_s    = copi_sync[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign ncs_rise  = ncs_s & ~ncs_d;
    assign ncs_fall  = ~ncs_s & ncs_d;
    assign addr      = sr[FRAME_W-2:8];

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else state_q <= state_n;
    end

    // An ncs rising edge wins over a coincident sclk edge, so that sclk edge is dropped.
    always_comb begin
        state_n  = state_q;
        shift_en = 1'b0;
        do_write = 1'b0;
        state_n  = (state_q == IDLE && ncs_fall) ? SHIFT :
                   (state_q == SHIFT && ncs_rise) ? COMMIT :
                   (state_q == COMMIT) ? IDLE : state_q;
        shift_en = (state_q == SHIFT) && sclk_rise && !ncs_rise;
        do_write = (state_q == COMMIT) && (cnt == CNT_FULL) && sr[FRAME_W-1] && (addr < ADDR_LIM);
    end

    // The counter stops at FRAME_W+1 so any overlong frame stays distinguishable from a full one.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            sr        <= '0;
            wr_strobe <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
        end else begin
            wr_strobe <= do_write;
            if (state_q == IDLE && ncs_fall) begin
                cnt <= '0;
                sr  <= '0;
            end else if (shift_en) begin
                sr <= {sr[FRAME_W-2:0], copi_s};
                if (cnt != CNT_OVER) cnt <= cnt + 1'b1;
            end
            for (int i = 0; i < NUM_REGS; i++)
                if (do_write && addr == ADDR_W'(i)) regs[i] <= sr[7:0];
        end
    end

    assign en_reg_out_7_0  = regs[0];
    assign en_reg_out_15_8 = regs[1];
    assign en_reg_pwm_7_0  = regs[2];
    assign en_reg_pwm_15_8 = regs[3];
    assign pwm_duty_cycle  = regs[4];

`ifdef SPI_READBACK_EN
    logic sclk_fall;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0] rd_data, out_sr;
    logic cipo_q;

    assign sclk_fall = ~sclk_s & sclk_d;
    // Header byte as it will stand once the in-flight bit is shifted in: R/W then address.
    assign rd_addr = {sr[ADDR_W-2:0], copi_s};

    always_comb begin
        rd_data = 8'h00;
        for (int i = 0; i < NUM_REGS; i++)
            if (!sr[ADDR_W-1] && rd_addr == ADDR_W'(i)) rd_data = regs[i];
    end

    // Load on the header's last rising edge; each following falling edge presents one data bit.
    always_ff @(posedge clk) begin
        if (rst || ncs_rise) begin
            out_sr <= 8'h00;
            cipo_q <= 1'b0;
        end else if (shift_en && cnt == CNT_W'(ADDR_W)) begin
            out_sr <= rd_data;
        end else if (state_q == SHIFT && sclk_fall && cnt > CNT_W'(ADDR_W) && cnt < CNT_FULL) begin
            {cipo_q, out_sr} <= {out_sr, 1'b0};
        end
    end

    assign cipo = cipo_q;
`else
    assign cipo = 1'b0;
`endif
endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: directed SPI frames against a register-bank model with a scoreboard queue.
module tb_spi_reg_bank;
    logic clk = 1'b0;
    logic rst, sclk, copi, ncs;
    logic cipo, wr_strobe;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;

    typedef struct {
        logic [4:0][7:0] regs;
        int strobes;
        logic [7:0] rx;
    } exp_t;

    exp_t sb[$];
    logic [7:0] model [5];
    int vectors = 0;
    int miscompares = 0;
    int strobe_cnt = 0;

    spi_reg_bank dut (
        .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle), .wr_strobe(wr_strobe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (wr_strobe !== 1'b0) strobe_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag, input logic [4:0][7:0] exp);
        check({tag, " reg0"}, {24'h0, en_reg_out_7_0}, {24'h0, exp[0]});
        check({tag, " reg1"}, {24'h0, en_reg_out_15_8}, {24'h0, exp[1]});
        check({tag, " reg2"}, {24'h0, en_reg_pwm_7_0}, {24'h0, exp[2]});
        check({tag, " reg3"}, {24'h0, en_reg_pwm_15_8}, {24'h0, exp[3]});
        check({tag, " reg4"}, {24'h0, pwm_duty_cycle}, {24'h0, exp[4]});
    endtask

    // Send n bits of v MSB first; optionally pulse rst after bit rst_at; then check after gap cycles.
    task automatic frame(input string tag, input logic [31:0] v, input int n, input int gap, input int rst_at);
        exp_t e, got;
        logic [6:0] a;
        int s0;
        logic [7:0] rx;
        a = v[14:8];
        e.strobes = 0;
        e.rx = 8'h00;
`ifdef SPI_READBACK_EN
        if (n == 16 && !v[15] && a < 7'd5) e.rx = model[a[2:0]];
`endif
        if (rst_at >= 0) begin
            for (int i = 0; i < 5; i++) model[i] = 8'h00;
            e.rx = 8'h00;
        end else if (n == 16 && v[15] && a < 7'd5) begin
            model[a[2:0]] = v[7:0];
            e.strobes = 1;
        end
        for (int i = 0; i < 5; i++) e.regs[i] = model[i];
        sb.push_back(e);
        s0 = strobe_cnt;
        rx = 8'h00;
        ncs = 1'b0;
        #100;
        for (int i = 0; i < n; i++) begin
            copi = v[n-1-i];
            #80;
            if (i >= 8 && i < 16) rx = {rx[6:0], cipo};
            sclk = 1'b1;
            #80;
            sclk = 1'b0;
            if (i == rst_at) begin
                @(posedge clk); #1 rst = 1'b1;
                @(posedge clk); #1 rst = 1'b0;
            end
        end
        #80 ncs = 1'b1;
        repeat (gap) @(posedge clk);
        #1;
        got.regs = {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
        got.strobes = strobe_cnt - s0;
        got.rx = rx;
        e = sb.pop_front();
        check_regs(tag, e.regs);
        check({tag, " wr_strobe cycles"}, got.strobes, e.strobes);
        check({tag, " cipo byte"}, {24'h0, got.rx}, {24'h0, e.rx});
        check({tag, " cipo idle"}, {31'h0, cipo}, 32'h0);
    endtask

    initial begin
        rst = 1'b1; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_regs("reset", '0);
        check("reset wr_strobe", {31'h0, wr_strobe}, 32'h0);
        check("reset cipo", {31'h0, cipo}, 32'h0);
        frame("w00", 32'h80F0, 16, 12, -1);
        frame("w04", 32'h8480, 16, 12, -1);
        frame("bad addr", 32'hB0AA, 16, 12, -1);
        frame("read04", 32'h0400, 16, 12, -1);
        frame("short", 32'h81FF >> 1, 15, 12, -1);
        frame("long", (32'h81FF << 1) | 32'h1, 17, 12, -1);
        frame("w02", 32'h82FF, 16, 12, -1);
        frame("rst mid", 32'h8201, 16, 12, 7);
        frame("b2b first", 32'h8311, 16, 6, -1);
        frame("b2b second", 32'h8322, 16, 12, -1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
